// File: rtl/service_rst_seq_if.sv
// Reset-sequencer board-side signals: PLL lock and button in, channel resets and ready out.
interface service_rst_seq_if #(
  parameter int unsigned NCH = 2
) ();
  logic           i_pll_locked;
  logic           i_btn;
  logic [NCH-1:0] o_rst;
  logic           o_ready;

  modport master (
    output i_pll_locked,
    output i_btn,
    input  o_rst,
    input  o_ready
  );

  modport slave (
    input  i_pll_locked,
    input  i_btn,
    output o_rst,
    output o_ready
  );
endinterface

// File: rtl/service_rst_sync.sv
// Two-flop synchroniser for an asynchronous level; both flops reset to RST_VAL.
module service_rst_sync #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic wb_clk,
  input  logic wb_rst,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/service_rst_seq.sv
// Board reset sequencer: power-on hold, staggered per-channel release, re-entry to hold on
// PLL lock loss or a debounced button press.
module service_rst_seq #(
  parameter int unsigned HOLD_CYCLES    = 64,
  parameter int unsigned NCH            = 2,
  parameter int unsigned STAGGER        = 16,
  parameter int unsigned DEBOUNCE_BITS  = 16,
  parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
  input logic              wb_clk,
  input logic              wb_rst,
  service_rst_seq_if.slave bus
);
  localparam int unsigned CntMax = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
  localparam int unsigned CW     = $clog2(CntMax + 1);
  localparam int unsigned IW     = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [CW-1:0] HoldLast = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] StagLast = CW'(STAGGER - 1);
  localparam logic [IW-1:0] IdxLast  = IW'(NCH - 1);

  typedef enum logic [1:0] {
    StHold = 2'd0,
    StRel  = 2'd1,
    StRun  = 2'd2
  } state_e;

  logic lock_s;
  logic btn_s;
  logic pressed_s;

  service_rst_sync #(
    .RST_VAL (1'b0)
  ) u_sync_lock (
    .wb_clk (wb_clk),
    .wb_rst (wb_rst),
    .d_i    (bus.i_pll_locked),
    .q_o    (lock_s)
  );

  // Button synchroniser resets to the released level for either polarity.
  service_rst_sync #(
    .RST_VAL (BTN_ACTIVE_LOW)
  ) u_sync_btn (
    .wb_clk (wb_clk),
    .wb_rst (wb_rst),
    .d_i    (bus.i_btn),
    .q_o    (btn_s)
  );

  assign pressed_s = btn_s ^ BTN_ACTIVE_LOW;

  logic [DEBOUNCE_BITS-1:0] db_cnt_q;
  logic                     db_q;

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      db_cnt_q <= '0;
      db_q     <= 1'b0;
    end else if (pressed_s != db_q) begin
      if (&db_cnt_q) begin
        db_q     <= ~db_q;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end else begin
      db_cnt_q <= '0;
    end
  end

  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  logic [IW-1:0]  idx_q;
  logic [NCH-1:0] rst_q;
  logic           ready_q;

  // A held debounced press behaves like lock loss: the sequence restarts from a full hold.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q <= StHold;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
    end else if (!lock_s || db_q) begin
      state_q <= StHold;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        StHold: begin
          if (cnt_q == HoldLast) begin
            state_q <= StRel;
            cnt_q   <= '0;
            idx_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRel: begin
          // cnt == 0 marks a release slot; it recurs every STAGGER cycles.
          if (cnt_q == '0) begin
            rst_q[idx_q] <= 1'b0;
            if (idx_q == IdxLast) begin
              state_q <= StRun;
              ready_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
          cnt_q <= (cnt_q >= StagLast) ? '0 : cnt_q + 1'b1;
        end
        StRun: begin
          rst_q   <= '0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= StHold;
        end
      endcase
    end
  end

  assign bus.o_rst   = rst_q;
  assign bus.o_ready = ready_q;
endmodule
